// File: rtl/adc_agc_ctrl_if.sv
// adc_agc_ctrl_if: configuration, sample and gain-control signals of the
// AGC block.
//   master : sample source / channel register block (drives inputs)
//   slave  : adc_agc_ctrl
//   inputs : enable, in (signed sample), valid_in, window, hi_thresh,
//            lo_thresh, hold
//   outputs: gain, gain_valid, locked, state, att
interface adc_agc_ctrl_if #(
  parameter int GAIN_WIDTH = 16
);
  logic                  enable;
  logic signed [7:0]     in;
  logic                  valid_in;
  logic [31:0]           window;
  logic [7:0]            hi_thresh;
  logic [7:0]            lo_thresh;
  logic [15:0]           hold;
  logic [GAIN_WIDTH-1:0] gain;
  logic                  gain_valid;
  logic                  locked;
  logic [1:0]            state;
  logic [1:0]            att;

  modport master (
    output enable, in, valid_in, window, hi_thresh, lo_thresh, hold,
    input  gain, gain_valid, locked, state, att
  );
  modport slave (
    input  enable, in, valid_in, window, hi_thresh, lo_thresh, hold,
    output gain, gain_valid, locked, state, att
  );
endinterface

// File: rtl/adc_agc_ctrl.sv
// adc_agc_ctrl: automatic gain controller for one ADC channel.
// Tracks the peak |sample| over a window of valid samples, then steps the
// gain word down (-1/8) on overload or up (+1/16, at least 1) on underload,
// clamped to [GAIN_MIN, GAIN_MAX], followed by an optional hold-off.
// Optional feature macro: AGC_ATT_EN -- at a gain limit, step the attenuator
// select instead and restart the gain at GAIN_INIT. Undefined: att = 0.
// Ports:
//   clk    : channel clock
//   resetn : asynchronous active-low reset
//   bus    : adc_agc_ctrl_if.slave (config/sample in, gain/status out)
module adc_agc_ctrl #(
  parameter int          GAIN_WIDTH = 16,
  parameter int unsigned GAIN_MIN   = 32'h0040,
  parameter int unsigned GAIN_MAX   = 32'h4000,
  parameter int unsigned GAIN_INIT  = 32'h0100
) (
  input logic            clk,
  input logic            resetn,
  adc_agc_ctrl_if.slave  bus
);
  localparam int GW = GAIN_WIDTH;
  localparam logic [GW-1:0] P_MIN  = GAIN_MIN[GW-1:0];
  localparam logic [GW-1:0] P_MAX  = GAIN_MAX[GW-1:0];
  localparam logic [GW-1:0] P_INIT = GAIN_INIT[GW-1:0];

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEAS = 2'd1, S_ADJ = 2'd2, S_HOLD = 2'd3} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_count, r_window;
  logic [7:0]    r_hi, r_lo;
  logic [8:0]    r_peak;
  logic [15:0]   r_hold, r_hcnt;
  logic [GW-1:0] r_gain;
  logic          r_gain_valid, r_locked;
  logic [1:0]    w_att, w_att_nxt;

  // 9-bit magnitude so that -128 maps to 128
  logic [8:0] w_in_ext, w_mag;
  assign w_in_ext = {bus.in[7], bus.in};
  assign w_mag    = bus.in[7] ? (9'd0 - w_in_ext) : w_in_ext;

  logic w_win_done, w_hi_hit, w_lo_hit;
  assign w_win_done = (r_count == r_window);
  assign w_hi_hit   = (r_peak > {1'b0, r_hi});
  assign w_lo_hit   = (r_peak < {1'b0, r_lo});

  // gain step candidates
  logic [GW-1:0] w_dec, w_dec_c, w_step, w_inc_c, w_gain_nxt;
  logic [GW:0]   w_inc;
  logic          w_changed;
  assign w_dec   = r_gain - (r_gain >> 3);
  assign w_dec_c = (w_dec < P_MIN) ? P_MIN : w_dec;
  assign w_step  = (r_gain[GW-1:4] == '0) ? {{(GW-1){1'b0}}, 1'b1} : (r_gain >> 4);
  assign w_inc   = {1'b0, r_gain} + {1'b0, w_step};
  assign w_inc_c = (w_inc > {1'b0, P_MAX}) ? P_MAX : w_inc[GW-1:0];

  // hi wins over lo when thresholds are misconfigured (lo > hi)
  always_comb begin
    w_gain_nxt = r_gain;
    w_att_nxt  = w_att;
    if (w_hi_hit) begin
`ifdef AGC_ATT_EN
      if (r_gain == P_MIN) begin
        w_att_nxt  = (w_att == 2'd3) ? 2'd3 : w_att + 2'd1;
        w_gain_nxt = P_INIT;
      end else
`endif
      w_gain_nxt = w_dec_c;
    end else if (w_lo_hit) begin
`ifdef AGC_ATT_EN
      if (r_gain == P_MAX) begin
        w_att_nxt  = (w_att == 2'd0) ? 2'd0 : w_att - 2'd1;
        w_gain_nxt = P_INIT;
      end else
`endif
      w_gain_nxt = w_inc_c;
    end
  end
  assign w_changed = (w_gain_nxt != r_gain) || (w_att_nxt != w_att);

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.enable) w_next = S_MEAS;
      S_MEAS: if (!bus.enable) w_next = S_IDLE;
              else if (w_win_done) w_next = S_ADJ;
      S_ADJ:  if (!bus.enable) w_next = S_IDLE;
              else if (w_changed && (bus.hold != 16'd0)) w_next = S_HOLD;
              else w_next = S_MEAS;
      S_HOLD: if (!bus.enable) w_next = S_IDLE;
              else if (r_hcnt + 16'd1 == r_hold) w_next = S_MEAS;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs / datapath controls
  logic w_clr, w_latch, w_accept, w_adjust;
  always_comb begin
    w_clr    = (r_state == S_IDLE);
    // every entry into MEASURE restarts the window with fresh config
    w_latch  = (w_next == S_MEAS) && (r_state != S_MEAS);
    // the sample after count reaches window is not taken; ADJUST follows
    w_accept = (r_state == S_MEAS) && bus.valid_in && !w_win_done;
    w_adjust = (r_state == S_ADJ);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count  <= '0;
      r_window <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_peak   <= '0;
    end else if (w_latch) begin
      r_count  <= '0;
      r_peak   <= '0;
      r_window <= (bus.window == 32'd0) ? 32'd1 : bus.window;
      r_hi     <= bus.hi_thresh;
      r_lo     <= bus.lo_thresh;
    end else if (w_clr) begin
      r_count  <= '0;
      r_peak   <= '0;
    end else if (w_accept) begin
      r_count  <= r_count + 32'd1;
      if (w_mag > r_peak) r_peak <= w_mag;
    end
  end

  // gain update happens in ADJUST even if enable drops in that cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gain       <= P_INIT;
      r_gain_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_gain_valid <= w_adjust && w_changed;
      if (w_adjust) begin
        r_gain   <= w_gain_nxt;
        r_locked <= !w_hi_hit && !w_lo_hit;
        r_hold   <= bus.hold;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                r_hcnt <= '0;
    else if (r_state == S_HOLD) r_hcnt <= r_hcnt + 16'd1;
    else                        r_hcnt <= '0;
  end

`ifdef AGC_ATT_EN
  logic [1:0] r_att;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_att <= 2'd0;
    else if (w_adjust) r_att <= w_att_nxt;
  end
  assign w_att = r_att;
`else
  assign w_att = 2'd0;
`endif

  assign bus.gain       = r_gain;
  assign bus.gain_valid = r_gain_valid;
  assign bus.locked     = r_locked;
  assign bus.state      = r_state;
  assign bus.att        = w_att;
endmodule

// File: tb/tb_adc_agc_ctrl.sv
// tb_adc_agc_ctrl: scoreboard bench for adc_agc_ctrl. Expected gain/att/
// locked/gain_valid and timing are pushed when a window's last sample is
// driven and popped the cycle after the DUT leaves ADJUST.
module tb_adc_agc_ctrl;
  localparam int GW = 16;
`ifdef AGC_ATT_EN
  localparam bit ATT_EN = 1'b1;
`else
  localparam bit ATT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  adc_agc_ctrl_if #(.GAIN_WIDTH(GW)) bus ();
  adc_agc_ctrl #(.GAIN_WIDTH(GW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic [15:0] gain;
    logic [1:0]  att;
    logic        locked;
    logic        gv;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0;
  int   gv_pulses = 0, exp_pulses = 0;
  int   m_gain = 256, m_att = 0;
  int   cfg_win = 4, cfg_hi = 100, cfg_lo = 20;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // reference adjust step, written from the gain rules
  function automatic exp_t model_adj(input int peak);
    exp_t e;
    int g = m_gain, a = m_att;
    bit lk = 1'b0;
    if (peak > cfg_hi) begin
      if (ATT_EN && g == 64) begin a = (a < 3) ? a + 1 : 3; g = 256; end
      else begin g = g - g / 8; if (g < 64) g = 64; end
    end else if (peak < cfg_lo) begin
      if (ATT_EN && g == 16384) begin a = (a > 0) ? a - 1 : 0; g = 256; end
      else begin g = g + ((g / 16 > 0) ? g / 16 : 1); if (g > 16384) g = 16384; end
    end else lk = 1'b1;
    e.gv     = (g != m_gain) || (a != m_att);
    e.gain   = g[15:0];
    e.att    = a[1:0];
    e.locked = lk;
    e.due    = 0;
    m_gain = g;
    m_att  = a;
    return e;
  endfunction

  // monitor: compare on the cycle after ADJUST
  bit   post_adj = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (bus.gain_valid === 1'b1) gv_pulses <= gv_pulses + 1;
    if (post_adj && resetn) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        me = sb.pop_front();
        chk("gain", bus.gain, me.gain);
        chk("gain_valid", bus.gain_valid, me.gv);
        chk("locked", bus.locked, me.locked);
        chk("att", bus.att, me.att);
        chk("latency", cyc, me.due);
      end
    end
    post_adj = (bus.state === 2'd2) && resetn;
  end

  task automatic wait_state(input int s, input int bound);
    int n = 0;
    while (bus.state !== s[1:0] && n < bound) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_state", bus.state, s);
  endtask

  task automatic set_cfg(input int win, input int hi, input int lo, input int hold);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    bus.window = win; bus.hi_thresh = hi[7:0]; bus.lo_thresh = lo[7:0]; bus.hold = hold[15:0];
    cfg_win = (win == 0) ? 1 : win; cfg_hi = hi; cfg_lo = lo;
    bus.enable = 1'b1;
    wait_state(1, 5);
  endtask

  // drives one full window (random valid gaps), pushes the expectation,
  // returns one cycle after ADJUST
  task automatic send_window(input int smp[$]);
    int   pk = 0;
    exp_t e;
    foreach (smp[i]) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.valid_in = 1'b0; bus.in = 8'sh7f;
        @(posedge clk); #1;
      end
      bus.in = 8'(smp[i]); bus.valid_in = 1'b1;
      if ((smp[i] < 0 ? -smp[i] : smp[i]) > pk) pk = (smp[i] < 0) ? -smp[i] : smp[i];
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    e = model_adj(pk);
    e.due = cyc + 2;
    if (e.gv) exp_pulses++;
    sb.push_back(e);
    wait_state(2, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int extra;
    resetn = 1'b0;
    bus.enable = 1'b0; bus.in = '0; bus.valid_in = 1'b0;
    bus.window = 4; bus.hi_thresh = 100; bus.lo_thresh = 20; bus.hold = 0;
    #23;
    chk("rst_gain", bus.gain, 16'h0100);
    chk("rst_state", bus.state, 0);
    chk("rst_gv", bus.gain_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_att", bus.att, 0);
    @(posedge clk); #1; resetn = 1'b1;

    // overload: 0x100 -> 0xE0
    set_cfg(4, 100, 20, 0);
    send_window('{10, -120, 5, 7});

    // async reset in the middle of a measurement
    wait_state(1, 5);
    bus.in = -100; bus.valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #2; resetn = 1'b0; #1;
    chk("mid_rst_gain", bus.gain, 16'h0100);
    chk("mid_rst_state", bus.state, 0);
    chk("mid_rst_gv", bus.gain_valid, 0);
    chk("mid_rst_att", bus.att, 0);
    bus.valid_in = 1'b0; m_gain = 256; m_att = 0;
    @(posedge clk); #1; resetn = 1'b1;

    // in-band, and peak exactly on each threshold
    wait_state(1, 5);
    send_window('{-50, 30, 25, -10});
    chk("inband_state", bus.state, 1);
    send_window('{100, -20, 5, 0});
    send_window('{20, -20, 3, 0});
    // lo > hi: overload wins
    set_cfg(1, 10, 50, 0);
    send_window('{30});
    // window 0 acts as 1; -128 has magnitude 128
    set_cfg(0, 127, 0, 0);
    send_window('{-128});

    // hold-off: exactly 10 HOLD cycles, samples during HOLD ignored
    set_cfg(4, 100, 20, 10);
    send_window('{-127, 0, 0, 0});
    n = 0;
    bus.in = -127; bus.valid_in = 1'b1;
    while (bus.state === 2'd3 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    bus.valid_in = 1'b0;
    chk("hold_cycles", n, 10);
    chk("after_hold", bus.state, 1);
    send_window('{30, -40, 25, 21});

    // enable drop discards partial measurement
    set_cfg(4, 100, 20, 0);
    bus.in = -127; bus.valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1; bus.valid_in = 1'b0; bus.enable = 1'b0;
    @(posedge clk); #1;
    chk("en_idle", bus.state, 0);
    bus.enable = 1'b1;
    wait_state(1, 5);
    send_window('{40, -30, 22, 0});

    // underload up to GAIN_MAX, then further windows
    extra = 0;
    for (int w = 0; w < 200 && extra < 3; w++) begin
      if (m_gain == 16384) extra++;
      wait_state(1, 5);
      send_window('{3, -4, 2, 1});
    end
    chk("reached_max", extra, 3);

    // overload down to GAIN_MIN (attenuator steps when enabled)
    extra = 0;
    for (int w = 0; w < 300 && extra < 4; w++) begin
      if (m_gain == 64) extra++;
      wait_state(1, 5);
      send_window('{-128, -128, -128, -128});
    end
    chk("reached_min", extra, 4);

    repeat (4) @(posedge clk);
    #1;
    chk("gv_pulses", gv_pulses, exp_pulses);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
